sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Copies a rectangular sprite of 4-bit palette indices from a sprite/area memory into the background frame-buffer RAM.
- Read side: drives the memory read port and consumes its data 1 cycle later.
- Write side: drives the frame-buffer write port (we/address/data).
- Game logic issues one blit per object per frame during vertical blank. Pixels equal to the transparent index are skipped; pixels off-screen are clipped.

Parameters:
FB_WIDTH, 316, frame-buffer width in pixels
FB_HEIGHT, 220, frame-buffer height in pixels
SRC_AW, 18, source memory address width
DST_AW, 17, frame-buffer address width
DW, 4, palette index width
TRANSPARENT, 4'h0, index never written

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
start  in  1  request blit; sampled only when idle
src_base  in  SRC_AW  source address of sprite pixel (0,0)
src_stride  in  10  source row pitch in pixels
w  in  9  sprite width
h  in  8  sprite height
dst_x  in  9  destination column of pixel (0,0)
dst_y  in  8  destination row of pixel (0,0)
busy  out  1  blit in progress
done  out  1  one-cycle completion pulse
src_addr  out  SRC_AW  read address to source memory
src_data  in  DW  source data; valid 1 cycle after src_addr
fb_we  out  1  frame-buffer write enable
fb_addr  out  DST_AW  frame-buffer write address
fb_data  out  DW  frame-buffer write data

Behaviour:
Interface and reset
- One clock, Clk. Reset is synchronous and active-low on Reset_n.
- Reset is sampled at posedge Clk. While asserted, the next edge forces: state IDLE, busy=0, done=0, fb_we=0, src_addr=0, fb_addr=0, fb_data=0.
- Reset mid-blit abandons the blit. No further fb_we pulses; the partially written frame buffer is left as is.

State machine
- States: IDLE, RUN, DRAIN, FIN.
- IDLE: on start=1, latch all inputs.
  - If w==0 or h==0, go to FIN.
  - Otherwise go to RUN with row r=0, col c=0.
- RUN: each cycle, present src_addr for (r,c) and advance c. At c==w-1, set c=0 and increment r. After pixel (h-1,w-1) is issued, go to DRAIN.
- DRAIN: 2 cycles flushing the pipeline, then FIN.
- FIN: done=1 for exactly 1 cycle, then IDLE.

Handshake and timing (cycle 1 = first cycle after the edge that samples start)
- src_addr for pixel n (raster order, N=w*h) is valid in cycle n+1.
- src_data for that pixel arrives in cycle n+2.
- fb_we/fb_addr/fb_data are registered and valid in cycle n+3.
- busy=1 from cycle 1 through cycle N+2. done=1 in cycle N+3 with busy=0.
- Throughput: 1 pixel/clock, no stalls.
- start is ignored while busy=1 or in FIN. A start in the cycle after done is accepted.
- Zero-size blit: done=1 in cycle 1, busy stays 0, no reads, no writes.

Address arithmetic (no multipliers)
- src_addr = src_base + r*src_stride + c, wrapping mod 2^SRC_AW. Implemented with a row-base accumulator plus column counter.
- fb_addr = (dst_y+r)*FB_WIDTH + dst_x + c. Implemented with a row accumulator stepping by FB_WIDTH, computed at 18 bits, truncated to DST_AW.
- Write condition: fb_we=1 only if src_data != TRANSPARENT and dst_x+c < FB_WIDTH and dst_y+r < FB_HEIGHT. Comparisons are at full width, so no wrap-around.
- Clip and column/row tags are pipelined alongside the address so they align with src_data.
- fb_addr and fb_data hold their last values when fb_we=0.

Decomposition:
- Package blit_pkg: state enum (IDLE, RUN, DRAIN, FIN), FB_WIDTH/FB_HEIGHT constants, TRANSPARENT, address width constants.
- One sub-module, blit_addr_gen: row/column counters, src/fb row-base accumulators, clip flags, last-pixel flag.
- Top level holds the FSM and the 2-stage alignment pipeline.

Test Plan:
- 2x2 sprite, src_base=0, stride=2, src mem {1,2,3,4}, dst=(0,0), start at edge 0:
  - fb_we high cycles 3–6 with (addr,data) = (0,1), (1,2), (316,3), (317,4).
  - done in cycle 7; busy high cycles 1–6.
- Same sprite with src mem {1,0,0,4}: fb_we only in cycle 3 (addr 0, data 1) and cycle 6 (addr 317, data 4); done still cycle 7.
- Clipping, dst=(315,219), 2x2 sprite {5,6,7,8}: single write, addr 219*316+315=69519, data 5, cycle 3; done cycle 7.
- w=0, h=5, start: done in cycle 1, busy never high, fb_we never high.
- Start ignored and reset mid-blit: 4x4 blit, start re-pulsed in cycle 2 is ignored. Reset_n=0 in cycle 5 gives fb_we=0, busy=0 from cycle 6, no done pulse. A new start after reset is accepted and completes normally.
- Back-to-back: 1x1 blits with start held high. Each completes: done pulse every 5 cycles, and each write lands 3 cycles after its start was sampled.

Source files
------------

// File: rtl/blit_pkg.sv
// blit_pkg: shared constants, FSM state type and a multiplier-free row-offset helper for the sprite blitter.
package blit_pkg;
    localparam int FB_WIDTH = 316;
    localparam int FB_HEIGHT = 220;
    localparam int SRC_AW = 18;
    localparam int DST_AW = 17;
    localparam int DW = 4;
    localparam logic [DW-1:0] TRANSPARENT = 4'h0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    // y * FB_WIDTH as a sum of shifted copies of y, one per set bit of the width
    function automatic logic [17:0] times_fb_width(input logic [7:0] y);
        logic [17:0] acc;
        acc = '0;
        for (int i = 0; i < 10; i++)
            if (FB_WIDTH[i]) acc = acc + (18'(y) << i);
        return acc;
    endfunction
endpackage

// File: rtl/blit_addr_gen.sv
// blit_addr_gen: raster walk over the sprite producing source/frame-buffer addresses,
// the on-screen flag and the last-pixel flag for the pixel currently being issued.
module blit_addr_gen
    import blit_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              load,
    input  logic              step,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [9:0]        src_stride,
    input  logic [8:0]        w,
    input  logic [7:0]        h,
    input  logic [8:0]        dst_x,
    input  logic [7:0]        dst_y,
    output logic [SRC_AW-1:0] src_addr,
    output logic [DST_AW-1:0] fb_addr,
    output logic              visible,
    output logic              last
);
    logic [8:0] c, w_l, x_l;
    logic [7:0] r, h_l, y_l;
    logic [9:0] stride_l;
    logic [SRC_AW-1:0] src_row;
    logic [17:0] fb_row;
    logic row_end;

    assign row_end = c == w_l - 9'd1;
    assign last = row_end && r == h_l - 8'd1;
    assign src_addr = src_row + SRC_AW'(c);
    assign fb_addr = DST_AW'(fb_row + 18'(x_l) + 18'(c));
    // widened compares so a sprite hanging off the right/bottom edge never wraps back on screen
    assign visible = ({1'b0, x_l} + {1'b0, c} < 10'(FB_WIDTH)) && ({1'b0, y_l} + {1'b0, r} < 9'(FB_HEIGHT));

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            c <= '0;
            r <= '0;
            w_l <= '0;
            h_l <= '0;
            x_l <= '0;
            y_l <= '0;
            stride_l <= '0;
            src_row <= '0;
            fb_row <= '0;
        end else if (load) begin
            c <= '0;
            r <= '0;
            w_l <= w;
            h_l <= h;
            x_l <= dst_x;
            y_l <= dst_y;
            stride_l <= src_stride;
            src_row <= src_base;
            fb_row <= times_fb_width(dst_y);
        end else if (step) begin
            c <= row_end ? '0 : c + 9'd1;
            if (row_end) begin
                r <= r + 8'd1;
                src_row <= src_row + SRC_AW'(stride_l);
                fb_row <= fb_row + 18'(FB_WIDTH);
            end
        end
    end
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a sprite of palette indices into the frame buffer at one pixel per
// clock, skipping transparent and off-screen pixels.
module sprite_blitter
    import blit_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [9:0]        src_stride,
    input  logic [8:0]        w,
    input  logic [7:0]        h,
    input  logic [8:0]        dst_x,
    input  logic [7:0]        dst_y,
    output logic              busy,
    output logic              done,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [DW-1:0]     src_data,
    output logic              fb_we,
    output logic [DST_AW-1:0] fb_addr,
    output logic [DW-1:0]     fb_data
);
    state_t state, next;
    logic load, drain_odd, p_valid, p_visible, gen_visible, gen_last, wr;
    logic [DST_AW-1:0] p_addr, gen_fb_addr;

    assign load = state == IDLE && start;
    assign busy = state == RUN || state == DRAIN;
    assign done = state == FIN;
    assign wr = p_valid && p_visible && src_data != TRANSPARENT;

    blit_addr_gen u_gen (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .load      (load),
        .step      (state == RUN),
        .src_base  (src_base),
        .src_stride(src_stride),
        .w         (w),
        .h         (h),
        .dst_x     (dst_x),
        .dst_y     (dst_y),
        .src_addr  (src_addr),
        .fb_addr   (gen_fb_addr),
        .visible   (gen_visible),
        .last      (gen_last)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = (w == '0 || h == '0) ? FIN : RUN;
            RUN:     if (gen_last) next = DRAIN;
            DRAIN:   if (drain_odd) next = FIN;
            default: next = IDLE;
        endcase
    end

    // p_* carry each pixel's tags one cycle so they meet its src_data
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
            drain_odd <= 1'b0;
            p_valid <= 1'b0;
            p_visible <= 1'b0;
            p_addr <= '0;
            fb_we <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            state <= next;
            drain_odd <= state == DRAIN && !drain_odd;
            p_valid <= state == RUN;
            p_visible <= gen_visible;
            p_addr <= gen_fb_addr;
            fb_we <= wr;
            if (wr) begin
                fb_addr <= p_addr;
                fb_data <= src_data;
            end
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized and directed checks of sprite_blitter against a per-cycle
// expectation table computed from the blit rules with plain arithmetic.
module tb_sprite_blitter;
    import blit_pkg::*;

    logic Clk = 1'b0, Reset_n = 1'b0, start = 1'b0;
    logic [17:0] src_base = '0;
    logic [9:0] src_stride = '0;
    logic [8:0] w = '0, dst_x = '0;
    logic [7:0] h = '0, dst_y = '0;
    logic busy, done, fb_we;
    logic [17:0] src_addr;
    logic [3:0] src_data = '0, fb_data;
    logic [16:0] fb_addr;

    logic [3:0] mem [0:262143];
    // per-cycle expectation: {busy, done, fb_we, fb_addr, fb_data}
    logic [23:0] ev [0:255];
    logic [16:0] last_addr;
    logic [3:0] last_data;
    logic any_write;
    int vectors = 0, miscompares = 0;

    sprite_blitter dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .src_base  (src_base),
        .src_stride(src_stride),
        .w         (w),
        .h         (h),
        .dst_x     (dst_x),
        .dst_y     (dst_y),
        .busy      (busy),
        .done      (done),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) src_data <= mem[src_addr];

    function automatic logic [23:0] observe();
        return {busy, done, fb_we, fb_we ? fb_addr : 17'd0, fb_we ? fb_data : 4'd0};
    endfunction

    task automatic predict();
        int n, a, fa, idx;
        logic [3:0] d;
        for (int k = 0; k < 256; k++) ev[k] = '0;
        any_write = 1'b0;
        if (w == 0 || h == 0) begin
            ev[1][22] = 1'b1;
            return;
        end
        n = int'(w) * int'(h);
        for (int k = 1; k <= n + 2; k++) ev[k][23] = 1'b1;
        ev[n + 3][22] = 1'b1;
        for (int r = 0; r < int'(h); r++)
            for (int c = 0; c < int'(w); c++) begin
                idx = r * int'(w) + c;
                a = (int'(src_base) + r * int'(src_stride) + c) & 'h3FFFF;
                d = mem[a];
                if (d != 4'h0 && int'(dst_x) + c < 316 && int'(dst_y) + r < 220) begin
                    fa = ((int'(dst_y) + r) * 316 + int'(dst_x) + c) & 'h1FFFF;
                    ev[idx + 3][21:0] = {1'b1, 17'(fa), d};
                    any_write = 1'b1;
                    last_addr = 17'(fa);
                    last_data = d;
                end
            end
    endtask

    task automatic fill_sprite();
        for (int r = 0; r < int'(h); r++)
            for (int c = 0; c < int'(w); c++)
                mem[18'(int'(src_base) + r * int'(src_stride) + c)] =
                    ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    endtask

    // leaves the bench at the falling edge inside cycle 1
    task automatic start_blit();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b expected 0", done); end
        vectors++; if (fb_we !== 1'b0) begin miscompares++; $display("FAIL reset_fb_we got %b expected 0", fb_we); end
        vectors++; if (src_addr !== 18'd0) begin miscompares++; $display("FAIL reset_src_addr got %h expected 0", src_addr); end
        vectors++; if (fb_addr !== 17'd0) begin miscompares++; $display("FAIL reset_fb_addr got %h expected 0", fb_addr); end
        vectors++; if (fb_data !== 4'd0) begin miscompares++; $display("FAIL reset_fb_data got %h expected 0", fb_data); end
        Reset_n = 1'b1;
    endtask

    task automatic test_plan();
        int pix [3][4] = '{'{1, 2, 3, 4}, '{1, 0, 0, 4}, '{5, 6, 7, 8}};
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) mem[j] = 4'(pix[i][j]);
            src_base = '0; src_stride = 10'd2; w = 9'd2; h = 8'd2;
            dst_x = (i == 2) ? 9'd315 : 9'd0;
            dst_y = (i == 2) ? 8'd219 : 8'd0;
            predict();
            start_blit();
            for (int k = 1; k <= 10; k++) begin
                vectors++;
                if (observe() !== ev[k]) begin
                    miscompares++;
                    $display("FAIL plan%0d cycle %0d got %h expected %h", i, k, observe(), ev[k]);
                end
                @(negedge Clk);
            end
            vectors++;
            if (any_write && {fb_addr, fb_data} !== {last_addr, last_data}) begin
                miscompares++;
                $display("FAIL plan%0d_hold got %h/%h expected %h/%h", i, fb_addr, fb_data, last_addr, last_data);
            end
        end
    endtask

    task automatic test_zero_size();
        for (int i = 0; i < 2; i++) begin
            w = (i == 0) ? 9'd0 : 9'd7;
            h = (i == 0) ? 8'd5 : 8'd0;
            predict();
            start_blit();
            for (int k = 1; k <= 5; k++) begin
                vectors++;
                if (observe() !== ev[k]) begin
                    miscompares++;
                    $display("FAIL zero%0d cycle %0d got %h expected %h", i, k, observe(), ev[k]);
                end
                @(negedge Clk);
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 24; t++) begin
            w = 9'($urandom_range(1, 12));
            h = 8'($urandom_range(1, 8));
            src_base = 18'($urandom);
            src_stride = 10'($urandom_range(0, 1023));
            dst_x = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(300, 511)) : 9'($urandom_range(0, 310));
            dst_y = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(210, 255)) : 8'($urandom_range(0, 200));
            fill_sprite();
            predict();
            n = int'(w) * int'(h);
            start_blit();
            for (int k = 1; k <= n + 5; k++) begin
                vectors++;
                if (observe() !== ev[k]) begin
                    miscompares++;
                    $display("FAIL rand%0d cycle %0d got %h expected %h", t, k, observe(), ev[k]);
                end
                @(negedge Clk);
            end
        end
    endtask

    task automatic test_abort();
        logic [23:0] exp;
        src_base = 18'd5000; src_stride = 10'd4; w = 9'd4; h = 8'd4; dst_x = 9'd100; dst_y = 8'd50;
        fill_sprite();
        mem[5000] = 4'h3;
        predict();
        start_blit();
        for (int k = 1; k <= 24; k++) begin
            exp = (k <= 5) ? ev[k] : 24'h0;
            vectors++;
            if (observe() !== exp) begin
                miscompares++;
                $display("FAIL abort cycle %0d got %h expected %h", k, observe(), exp);
            end
            if (k == 2) begin start = 1'b1; w = 9'd0; end
            if (k == 3) start = 1'b0;
            if (k == 5) Reset_n = 1'b0;
            if (k == 8) Reset_n = 1'b1;
            @(negedge Clk);
        end
        vectors++; if (src_addr !== 18'd0) begin miscompares++; $display("FAIL abort_src_addr got %h expected 0", src_addr); end
        vectors++; if (fb_addr !== 17'd0) begin miscompares++; $display("FAIL abort_fb_addr got %h expected 0", fb_addr); end
        src_base = 18'd7000; src_stride = 10'd3; w = 9'd3; h = 8'd2; dst_x = 9'd20; dst_y = 8'd30;
        fill_sprite();
        predict();
        start_blit();
        for (int k = 1; k <= 11; k++) begin
            vectors++;
            if (observe() !== ev[k]) begin
                miscompares++;
                $display("FAIL after_abort cycle %0d got %h expected %h", k, observe(), ev[k]);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp;
        int m;
        src_base = 18'd1000; src_stride = 10'd1; w = 9'd1; h = 8'd1; dst_x = 9'd10; dst_y = 8'd20;
        mem[1000] = 4'h9;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        // four blits: started at cycle 0 and at the idle cycles 5, 10 and 15
        for (int k = 1; k <= 23; k++) begin
            m = k % 5;
            exp = '0;
            if (k <= 20) begin
                exp[23] = m >= 1 && m <= 3;
                exp[22] = m == 4;
                if (m == 3) exp[21:0] = {1'b1, 17'(20 * 316 + 10), 4'h9};
            end
            vectors++;
            if (observe() !== exp) begin
                miscompares++;
                $display("FAIL b2b cycle %0d got %h expected %h", k, observe(), exp);
            end
            if (k == 16) start = 1'b0;
            @(negedge Clk);
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_zero_size();
        test_random();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
